freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
Gated edge counter downstream of freq_divider. It measures the divided signal freq_in, which is asynchronous to clk.
- freq_in is synchronised into the clk domain and its rising edges are counted over a fixed window of GATE_CYCLES clk cycles.
- At the end of the window the block latches the count and pulses valid.
- Software computes f = count * upstream DIVISOR-factor * f_clk / GATE_CYCLES.

Parameters:
GATE_CYCLES, 1000000, gate window length in clk cycles (>=2)
CNT_W, 32, width of edge and result counters
SYNC_STAGES, 2, synchroniser flops on freq_in (>=2)

Ports:
clk  in  1  reference clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin one measurement; sampled only in IDLE
freq_in  in  1  asynchronous measured signal (freq_divider output)
busy  out  1  high while state != IDLE
count  out  CNT_W  edges in last completed window; held until next window completes
valid  out  1  one-cycle pulse when count/overflow update
overflow  out  1  edge counter saturated in last completed window

Behaviour:
- Reset (rst=1 at a clk edge): applies in any state, including mid-window. Effects:
  - state=WARMUP, count=0, valid=0, overflow=0, busy=1.
  - gate counter, edge counter and overflow flag cleared; synchroniser and edge-detect flops cleared.
  - No partial result is emitted.
- Edge detection:
  - freq_in passes through SYNC_STAGES flops, then one delay flop; edge = sync & ~delayed.
  - Latency from a freq_in rise to a counted edge is SYNC_STAGES+1 clk.
  - freq_in high pulses shorter than 1 clk are not guaranteed to be counted.
  - Max measurable freq_in rate is f_clk/2.
- WARMUP:
  - Lasts exactly SYNC_STAGES+1 cycles after rst deasserts, so a spurious edge caused by freq_in being high at reset release is flushed.
  - start is ignored; busy=1.
  - Then -> IDLE.
- IDLE: busy=0. start=1 -> GATE on the next clk, with gate counter=0, edge counter=0 and overflow flag=0.
- GATE:
  - Runs exactly GATE_CYCLES clk cycles; the first GATE cycle is the cycle after start is accepted.
  - Each cycle with edge=1 increments the edge counter.
  - At all-ones the edge counter saturates and sets the internal overflow flag; it never wraps.
  - start is ignored.
- End of window (last GATE cycle, gate counter == GATE_CYCLES-1):
  - An edge in this cycle is counted in the window.
  - Next clk: count <= final edge count, overflow <= flag, valid=1 for exactly one cycle, state -> IDLE.
  - busy is 0 in the valid cycle; start in that cycle is accepted.
- count/overflow change only on valid cycles or on reset.

Optional Feature:
Macro FREQ_METER_CONT_EN.
- Defined (continuous mode):
  - After the first accepted start, the last GATE cycle transitions directly to a new GATE window. Gate counter, edge counter and flag restart; there are no dead cycles.
  - An edge in the last cycle belongs to the old window; an edge in the first cycle of the new window belongs to the new one.
  - valid pulses every GATE_CYCLES clk; busy stays 1 until reset.
- Undefined: single-shot behaviour as above.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (WARMUP, IDLE, GATE);
  - the function computing gate counter width as clog2(GATE_CYCLES);
  - the warm-up length constant, SYNC_STAGES+1.
- Sub-module sync_edge_detect (param SYNC_STAGES; ports clk, rst, din, edge): synchroniser plus rising-edge pulse, reusable across the frequency_counter tree.

Test Plan:
- GATE_CYCLES=100; freq_in square wave, period 10 clk; start once after warm-up -> count=10 (±1 for phase), valid one cycle exactly 101 clk after start accepted, overflow=0.
- start asserted during the first SYNC_STAGES+1 cycles after reset, with freq_in held high through reset -> start ignored, busy=1; a later start with freq_in static high -> count=0.
- CNT_W=4, GATE_CYCLES=100, freq_in period 4 clk -> count=15, overflow=1; next window with freq_in period 20 -> count=5, overflow=0.
- rst pulsed at GATE cycle 50 -> next clk count=0, valid=0, state WARMUP; no valid ever emitted for the aborted window.
- start held high continuously, GATE_CYCLES=100 -> valid pulses every 101 clk; start pulses during GATE are ignored (count unaffected).
- FREQ_METER_CONT_EN defined, GATE_CYCLES=100, freq_in period 5 -> valid every 100 clk, each count=20, busy stays 1.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the freq_meter gated edge counter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        GATE
    } state_t;

    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
    endfunction

    function automatic int warmup_len(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised freq_in rises over GATE_CYCLES clk cycles.
// Define FREQ_METER_CONT_EN for back-to-back (continuous) measurement windows.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             freq_in,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);

    localparam int GW = gate_cnt_w(GATE_CYCLES);
    localparam int WL = warmup_len(SYNC_STAGES);
    localparam int WW = $clog2(WL + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WL - 1);

    state_t           state;
    logic [WW-1:0]    warm_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_cnt_nxt;
    logic             flag;
    logic             flag_nxt;
    logic             edge_pulse;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .din       (freq_in),
        .edge_pulse(edge_pulse)
    );

    // Saturating increment: an edge arriving at all-ones is lost and flagged.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        flag_nxt     = flag;
        if (edge_pulse) begin
            if (&edge_cnt) begin
                flag_nxt = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WARMUP;
            busy     <= 1'b1;
            warm_cnt <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            flag     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        flag     <= 1'b0;
                    end
                end
                GATE: begin
                    edge_cnt <= edge_cnt_nxt;
                    flag     <= flag_nxt;
                    if (gate_cnt == GATE_LAST) begin
                        // The edge seen in the last cycle still belongs to this window.
                        count    <= edge_cnt_nxt;
                        overflow <= flag_nxt;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
`ifdef FREQ_METER_CONT_EN
                        edge_cnt <= '0;
                        flag     <= 1'b0;
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
`endif
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= WARMUP;
                    busy     <= 1'b1;
                    warm_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (32-bit and 4-bit counters) share all inputs.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        freq_in = 1'b1;
    logic        busy, valid, overflow;
    logic [31:0] count;
    logic        busy4, valid4, overflow4;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;
    int period = 0;
    logic hold_level = 1'b1;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .freq_in(freq_in),
        .busy(busy), .count(count), .valid(valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .start(start), .freq_in(freq_in),
        .busy(busy4), .count(count4), .valid(valid4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    // Square wave generator: high for period/2 of every period clk cycles.
    int ph = 0;
    int last_period = 0;
    always @(negedge clk) begin
        if (period != last_period) begin
            ph = 0;
            last_period = period;
        end
        if (period == 0) begin
            freq_in = hold_level;
        end else begin
            freq_in = (ph < period / 2);
            ph = (ph + 1) % period;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < 300);
        check("valid_seen", valid, 1);
    endtask

    task automatic start_and_wait(output int n);
        int m;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        if (!valid) begin
            wait_valid(m);
            n += m;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int vcnt;

        // Reset with freq_in held high
        step(3);
        check("rst_busy", busy, 1);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count4", count4, 0);

        // Start during warm-up is ignored
        rst = 1'b0;
        start = 1'b1;
        step();
        check("warm_busy1", busy, 1);
        step();
        check("warm_busy2", busy, 1);
        step();
        check("warm_to_idle_busy", busy, 0);
        start = 1'b0;
        step(2);
        check("warm_start_ignored_busy", busy, 0);
        check("warm_start_ignored_valid", valid, 0);

`ifdef FREQ_METER_CONT_EN
        period = 5;
        step(30);
        start_and_wait(n);
        check("cont_first_latency", n, 101);
        check("cont_first_count", count, 20);
        check("cont_first_busy", busy, 1);
        check("cont_count4", count4, 15);
        check("cont_ovf4", overflow4, 1);
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            check("cont_interval", n, 100);
            check("cont_count", count, 20);
            check("cont_busy", busy, 1);
            check("cont_ovf", overflow, 0);
        end
`else
        // Static high input: no edges
        start_and_wait(n);
        check("static_latency", n, 101);
        check("static_count", count, 0);
        check("static_ovf", overflow, 0);
        check("static_busy_in_valid", busy, 0);
        step();
        check("static_valid_one_cycle", valid, 0);

        // Period 10 square wave
        period = 10;
        step(30);
        start_and_wait(n);
        check("p10_latency", n, 101);
        check("p10_count", count, 10);
        check("p10_ovf", overflow, 0);
        check("p10_count4", count4, 10);
        step(5);
        check("p10_valid_low", valid, 0);
        check("p10_count_held", count, 10);

        // Saturation on the 4-bit instance
        period = 4;
        step(30);
        start_and_wait(n);
        check("p4_count", count, 25);
        check("p4_ovf", overflow, 0);
        check("p4_count4", count4, 15);
        check("p4_ovf4", overflow4, 1);
        period = 20;
        step(30);
        start_and_wait(n);
        check("p20_count", count, 5);
        check("p20_count4", count4, 5);
        check("p20_ovf4", overflow4, 0);

        // start held high: back-to-back windows, 101 clk apart
        period = 10;
        step(30);
        start = 1'b1;
        wait_valid(n);
        check("held_first_count", count, 10);
        wait_valid(n);
        check("held_interval1", n, 101);
        check("held_count1", count, 10);
        wait_valid(n);
        start = 1'b0;
        check("held_interval2", n, 101);
        check("held_count2", count, 10);
        step(2);
        check("held_released_busy", busy, 0);

        // Reset in the middle of a window
        start = 1'b1;
        step();
        start = 1'b0;
        step(50);
        check("abort_busy_mid", busy, 1);
        rst = 1'b1;
        step();
        check("abort_count", count, 0);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 1);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        check("abort_idle_busy", busy, 0);
        check("abort_count_held", count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
